// File: rtl/uart_rx_edge_bit_sampler_if.sv
// Signal bundle between the receiver FSM (master) and the oversampling
// edge/bit sampler (slave).
interface uart_rx_edge_bit_sampler_if;
  logic       RX_IN;
  logic [5:0] prescale;
  logic       edge_bit_enable;
  logic       data_sampler_enable;
  logic       rx_sync;
  logic [5:0] edge_count;
  logic [4:0] bit_count;
  logic       sampled_bit;
  logic       sample_done;
  logic       bit_done;

  modport master (
    output RX_IN, prescale, edge_bit_enable, data_sampler_enable,
    input  rx_sync, edge_count, bit_count, sampled_bit, sample_done, bit_done
  );

  modport slave (
    input  RX_IN, prescale, edge_bit_enable, data_sampler_enable,
    output rx_sync, edge_count, bit_count, sampled_bit, sample_done, bit_done
  );
endinterface

// File: rtl/uart_rx_edge_bit_sampler.sv
// UART receive front end: synchronises RX_IN, counts oversampling edges and
// bit periods, and majority-votes three mid-bit samples into sampled_bit.
module uart_rx_edge_bit_sampler (
  input  logic                          clk_based_on_prescale,
  input  logic                          asy_reset,
  uart_rx_edge_bit_sampler_if.slave     bus
);

  logic       rx_s1_q, rx_s1_d;
  logic       rx_s2_q, rx_s2_d;
  logic       en_q, en_d;
  logic [5:0] prescale_q, prescale_d;
  logic [5:0] edge_count_q, edge_count_d;
  logic [4:0] bit_count_q, bit_count_d;
  logic       s0_q, s0_d;
  logic       s1_q, s1_d;
  logic       v0_q, v0_d;
  logic       v1_q, v1_d;
  logic       sampled_bit_q, sampled_bit_d;
  logic       sample_done_q, sample_done_d;

  logic       capture;
  logic [5:0] legal_p;
  logic [5:0] p_eff;
  logic [5:0] mid;
  logic       take;

  // The capture cycle must already count with the new ratio, so the
  // effective P bypasses prescale_q on that cycle.
  always_comb begin
    capture = bus.edge_bit_enable && !en_q;
    legal_p = (bus.prescale == 6'd8 || bus.prescale == 6'd16 || bus.prescale == 6'd32)
              ? bus.prescale : 6'd8;
    p_eff   = capture ? legal_p : prescale_q;
    mid     = p_eff >> 1;
    take    = bus.edge_bit_enable && bus.data_sampler_enable;
  end

  always_comb begin
    rx_s1_d       = bus.RX_IN;
    rx_s2_d       = rx_s1_q;
    en_d          = bus.edge_bit_enable;
    prescale_d    = p_eff;
    edge_count_d  = '0;
    bit_count_d   = '0;
    s0_d          = s0_q;
    s1_d          = s1_q;
    v0_d          = v0_q;
    v1_d          = v1_q;
    sampled_bit_d = sampled_bit_q;
    sample_done_d = 1'b0;

    if (bus.edge_bit_enable) begin
      if (edge_count_q == p_eff - 6'd1) begin
        edge_count_d = '0;
        bit_count_d  = (bit_count_q == 5'd31) ? bit_count_q : bit_count_q + 5'd1;
      end else begin
        edge_count_d = edge_count_q + 6'd1;
        bit_count_d  = bit_count_q;
      end
    end

    // Valid flags guarantee both early samples belong to the current bit.
    if (!bus.edge_bit_enable || edge_count_q == 6'd0) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
    end

    if (take) begin
      if (edge_count_q == mid - 6'd1) begin
        s0_d = rx_s2_q;
        v0_d = 1'b1;
      end
      if (edge_count_q == mid) begin
        s1_d = rx_s2_q;
        v1_d = 1'b1;
      end
      if (edge_count_q == mid + 6'd1 && v0_q && v1_q) begin
        sampled_bit_d = (s0_q & s1_q) | (s0_q & rx_s2_q) | (s1_q & rx_s2_q);
        sample_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_based_on_prescale) begin
    if (asy_reset) begin
      rx_s1_q       <= 1'b1;
      rx_s2_q       <= 1'b1;
      en_q          <= 1'b0;
      prescale_q    <= 6'd8;
      edge_count_q  <= '0;
      bit_count_q   <= '0;
      s0_q          <= 1'b1;
      s1_q          <= 1'b1;
      v0_q          <= 1'b0;
      v1_q          <= 1'b0;
      sampled_bit_q <= 1'b1;
      sample_done_q <= 1'b0;
    end else begin
      rx_s1_q       <= rx_s1_d;
      rx_s2_q       <= rx_s2_d;
      en_q          <= en_d;
      prescale_q    <= prescale_d;
      edge_count_q  <= edge_count_d;
      bit_count_q   <= bit_count_d;
      s0_q          <= s0_d;
      s1_q          <= s1_d;
      v0_q          <= v0_d;
      v1_q          <= v1_d;
      sampled_bit_q <= sampled_bit_d;
      sample_done_q <= sample_done_d;
    end
  end

  assign bus.rx_sync     = rx_s2_q;
  assign bus.edge_count  = edge_count_q;
  assign bus.bit_count   = bit_count_q;
  assign bus.sampled_bit = sampled_bit_q;
  assign bus.sample_done = sample_done_q;
  assign bus.bit_done    = bus.edge_bit_enable && (edge_count_q == prescale_q - 6'd1);

endmodule

// File: tb/tb_uart_rx_edge_bit_sampler.sv
// Directed plus randomized bench for uart_rx_edge_bit_sampler, checked every
// cycle against a run-length/arithmetic reference model.
module tb_uart_rx_edge_bit_sampler;
  localparam int N = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_edge_bit_sampler_if bus();

  uart_rx_edge_bit_sampler dut (
    .clk_based_on_prescale (clk),
    .asy_reset             (rst),
    .bus                   (bus)
  );

  int tests = 0;
  int fails = 0;
  int done_seen;

  // Reference model: m_c = consecutive enabled cycles before this one.
  int m_c, m_p;
  bit m_en, m_ok, m_done, m_sb, m_s1, m_s2;
  int m_v0, m_v1;

  bit         pl_rst [N];
  bit         pl_ebe [N];
  bit         pl_dse [N];
  bit         pl_rx  [N];
  logic [5:0] pl_pre [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int legal(input int p);
    return (p == 8 || p == 16 || p == 32) ? p : 8;
  endfunction

  task automatic model_reset();
    m_c = 0; m_p = 8; m_en = 0; m_ok = 0; m_done = 0; m_sb = 1;
    m_s1 = 1; m_s2 = 1; m_v0 = 1; m_v1 = 1;
  endtask

  task automatic model_update();
    int ph, mid;
    bit nd;
    nd = 0;
    if (rst) begin
      model_reset();
      return;
    end
    if (bus.edge_bit_enable) begin
      if (!m_en) m_p = legal(int'(bus.prescale));
      ph  = m_c % m_p;
      mid = m_p / 2;
      if (ph == 0) m_ok = 1;
      if (ph == mid - 1) begin
        if (bus.data_sampler_enable) m_v0 = m_s2; else m_ok = 0;
      end
      if (ph == mid) begin
        if (bus.data_sampler_enable) m_v1 = m_s2; else m_ok = 0;
      end
      if (ph == mid + 1 && bus.data_sampler_enable && m_ok) begin
        nd   = 1;
        m_sb = (m_v0 + m_v1 + int'(m_s2)) >= 2;
      end
      m_c++;
    end else begin
      m_c  = 0;
      m_ok = 0;
    end
    m_done = nd;
    m_s2   = m_s1;
    m_s1   = bus.RX_IN;
    m_en   = bus.edge_bit_enable;
  endtask

  task automatic do_cycle();
    int ec, bc;
    @(negedge clk);
    ec = m_c % m_p;
    bc = m_c / m_p;
    if (bc > 31) bc = 31;
    check("rx_sync",     bus.rx_sync,     m_s2);
    check("edge_count",  bus.edge_count,  ec);
    check("bit_count",   bus.bit_count,   bc);
    check("sampled_bit", bus.sampled_bit, m_sb);
    check("sample_done", bus.sample_done, m_done);
    check("bit_done",    bus.bit_done,    bus.edge_bit_enable && (ec == m_p - 1));
    if (bus.sample_done === 1'b1) done_seen++;
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic plan_fill(input int len, input bit ebe, input bit dse, input bit rx, input logic [5:0] pre);
    for (int i = 0; i < len; i++) begin
      pl_rst[i] = 0; pl_ebe[i] = ebe; pl_dse[i] = dse; pl_rx[i] = rx; pl_pre[i] = pre;
    end
  endtask

  task automatic run_plan(input int len);
    done_seen = 0;
    for (int i = 0; i < len; i++) begin
      rst                     = pl_rst[i];
      bus.RX_IN               = pl_rx[i];
      bus.edge_bit_enable     = pl_ebe[i];
      bus.data_sampler_enable = pl_dse[i];
      bus.prescale            = pl_pre[i];
      do_cycle();
    end
  endtask

  initial begin
    int s, p, nbits, len, sel;
    logic [5:0] pres [6];
    bit bits [16];
    pres[0] = 6'd8; pres[1] = 6'd16; pres[2] = 6'd32;
    pres[3] = 6'd12; pres[4] = 6'd0; pres[5] = 6'd63;
    s = 3;

    rst = 1'b1;
    bus.RX_IN = 1'b0; bus.edge_bit_enable = 1'b1;
    bus.data_sampler_enable = 1'b1; bus.prescale = 6'd8;
    model_reset();
    @(posedge clk);
    #1;

    // Reset held with line low and enables high
    plan_fill(2, 1, 1, 0, 6'd8);
    for (int i = 0; i < 2; i++) pl_rst[i] = 1;
    run_plan(2);

    // P=8, line low, one bit
    plan_fill(s + 8 + 3, 0, 1, 0, 6'd8);
    for (int i = s; i < s + 8; i++) pl_ebe[i] = 1;
    run_plan(s + 11);
    check("p8_done_count", done_seen, 1);
    check("p8_bit", bus.sampled_bit, 0);

    // Glitch at edge_count 4 only, then at 4 and 5
    plan_fill(s + 8 + 3, 0, 1, 0, 6'd8);
    for (int i = s; i < s + 8; i++) pl_ebe[i] = 1;
    pl_rx[s + 2] = 1;
    run_plan(s + 11);
    check("glitch1_bit", bus.sampled_bit, 0);
    pl_rx[s + 3] = 1;
    run_plan(s + 11);
    check("glitch2_bit", bus.sampled_bit, 1);
    check("glitch2_done_count", done_seen, 1);

    // P=16, ten alternating bits aligned to the counter
    plan_fill(s + 160 + 3, 0, 1, 1, 6'd16);
    for (int i = 0; i < s + 163; i++) begin
      if (i - s + 2 >= 0 && i - s + 2 < 160) pl_rx[i] = ((i - s + 2) / 16) % 2;
      if (i >= s && i < s + 160) pl_ebe[i] = 1;
    end
    run_plan(s + 163);
    check("p16_done_count", done_seen, 10);
    check("p16_last_bit", bus.sampled_bit, 1);

    // Prescale 16 -> 8 mid-frame, then illegal 12 at frame start
    plan_fill(s + 40 + 3, 0, 1, 0, 6'd16);
    for (int i = s; i < s + 40; i++) pl_ebe[i] = 1;
    for (int i = s + 20; i < s + 43; i++) pl_pre[i] = 6'd8;
    run_plan(s + 43);
    check("pchange_done_count", done_seen, 2);
    plan_fill(s + 20 + 3, 0, 1, 1, 6'd12);
    for (int i = s; i < s + 20; i++) pl_ebe[i] = 1;
    run_plan(s + 23);
    check("illegal_done_count", done_seen, 2);

    // Enable dropped at edge_count 5 of bit 2, then sampler enable dropped at mid
    plan_fill(s + 39 + 48 + 3, 0, 1, 0, 6'd16);
    for (int i = s; i < s + 37; i++) pl_ebe[i] = 1;
    for (int i = s + 39; i < s + 87; i++) pl_ebe[i] = 1;
    for (int i = s + 20; i < s + 90; i++) pl_rx[i] = 1;
    pl_dse[s + 39 + 16 + 8] = 0;
    run_plan(s + 90);
    check("drop_done_count", done_seen, 4);

    // Saturation of bit_count
    plan_fill(s + 35 * 8 + 2, 0, 1, 1, 6'd8);
    for (int i = s; i < s + 35 * 8; i++) pl_ebe[i] = 1;
    run_plan(s + 35 * 8 + 2);

    // Randomized frames with occasional glitches, dropouts and resets
    for (int f = 0; f < 16; f++) begin
      sel   = $urandom_range(0, 5);
      p     = legal(int'(pres[sel]));
      nbits = $urandom_range(1, 10);
      len   = s + nbits * p + 4;
      for (int b = 0; b < 16; b++) bits[b] = $urandom_range(0, 1);
      plan_fill(len, 0, 1, 1, pres[sel]);
      for (int i = 0; i < len; i++) begin
        if (i - s + 2 >= 0 && (i - s + 2) / p < nbits) pl_rx[i] = bits[(i - s + 2) / p];
        if ($urandom_range(0, 15) == 0) pl_rx[i] = ~pl_rx[i];
        if (i >= s && i < s + nbits * p) pl_ebe[i] = ($urandom_range(0, 199) != 0);
        pl_dse[i] = ($urandom_range(0, 39) != 0);
        if ($urandom_range(0, 20) == 0) pl_pre[i] = pres[$urandom_range(0, 5)];
        pl_rst[i] = ($urandom_range(0, 499) == 0);
      end
      run_plan(len);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_edge_bit_sampler.md
# uart_rx_edge_bit_sampler

Oversampling front end of the UART receiver: synchronises RX_IN, counts oversampling edges and bit periods, and produces a majority-voted bit value at mid-bit. It sits directly upstream of the receiver FSM, deserializer and start/parity/stop checkers. The FSM drives its enables, and consumes its edge_count, bit_count and sampled_bit outputs.

## Interface
- No parameters; oversampling ratio is a run-time input.
- clk_based_on_prescale  in  1  oversampled receiver clock; all state updates on rising edge
- asy_reset  in  1  reset, synchronous, active-high (name kept for codebase consistency)
- RX_IN  in  1  raw serial line, idle high, asynchronous to clock
- prescale  in  6  oversampling ratio P; legal values 8, 16, 32
- edge_bit_enable  in  1  from FSM; runs counters while high
- data_sampler_enable  in  1  from FSM; permits sample capture while high
- rx_sync  out  1  RX_IN after 2-flop synchroniser
- edge_count  out  6  oversampling edge index within current bit, 0..P-1
- bit_count  out  5  completed bit periods since enable rose, saturates at 31
- sampled_bit  out  1  majority-voted value of most recent bit
- sample_done  out  1  one-cycle pulse: sampled_bit just updated
- bit_done  out  1  high while edge_count == P-1 and edge_bit_enable == 1

## Operation
- Reset has priority over all other inputs. Reset values: sync flops 1, rx_sync 1, edge_count 0, bit_count 0, sampled_bit 1, sample_done 0, stored samples 1, prescale_q 8, en_q 0.
- Synchroniser: rx_s1 <= RX_IN, rx_s2 <= rx_s1; rx_sync = rx_s2. All sampling uses rx_s2.
- Prescale capture: en_q registers edge_bit_enable. On a cycle with edge_bit_enable=1 and en_q=0, prescale_q <= prescale if it is 8, 16 or 32, else 8. prescale_q is held otherwise, so prescale changes mid-frame are ignored. The capture cycle itself counts with the newly captured P.
- Counters, edge_bit_enable=1:
  - edge_count == P-1: edge_count <= 0; bit_count <= bit_count+1, held at 31 once it reaches 31.
  - Otherwise: edge_count <= edge_count+1.
- Counters, edge_bit_enable=0: edge_count <= 0, bit_count <= 0 on the next edge. No partial-bit state survives.
- Sampling, with mid = P/2 (4, 8, 16); all captures require data_sampler_enable=1 and edge_bit_enable=1:
  - edge_count == mid-1: s0 <= rx_s2.
  - edge_count == mid: s1 <= rx_s2.
  - edge_count == mid+1: sampled_bit <= majority(s0, s1, rx_s2) and sample_done <= 1. This update occurs only if s0 and s1 were both captured in this bit period; track this with a per-bit valid flag that clears at edge_count 0.
- sample_done is 0 on every other cycle, so it is exactly one cycle wide and is high while edge_count == mid+2.
- Missed sample: if data_sampler_enable is low at any of the three sample points, that bit produces no sample_done and sampled_bit holds its previous value.
- Enable dropped mid-bit: counters clear, the valid flag clears, and no sample_done is produced for that bit.
- bit_done is combinational from registered edge_count, prescale_q and edge_bit_enable.

## Timing
- RX_IN to rx_sync: 2 cycles.
- edge_bit_enable rising to first edge_count increment: 1 cycle. edge_count reads 0 during the first enabled cycle.
- Bit k (k from 0) spans enabled cycles k·P .. k·P+P-1. bit_count reads k+1 at cycle (k+1)·P.
- sample_done for bit k: cycle k·P + mid + 2. Votes use rx_s2 at edge_count mid-1, mid and mid+1.
- Throughput: one vote per P cycles; no back-pressure.

## Test plan
- Reset: assert asy_reset 2 cycles with RX_IN=0 and enables=1. All outputs equal their reset values, and edge_count stays 0 throughout.
- P=8, RX_IN held 0, both enables high for 8 cycles: sample_done pulses once while edge_count=6; sampled_bit=0; bit_count=1 after cycle 8; bit_done high while edge_count=7.
- Glitch rejection, P=8, line 0: force rx_s2=1 only at edge_count=4. sampled_bit=0. Force rx_s2=1 at counts 4 and 5: sampled_bit=1.
- P=16, 10 bits of alternating 0/1 timed to the counter: ten sample_done pulses at edge_count 10, sampled_bit matches each bit, bit_count=10 after 160 cycles.
- Mid-frame prescale change 16->8 at cycle 20: bit period stays 16. Illegal prescale=12 at frame start: bit period is 8.
- Drop edge_bit_enable at edge_count=5 of bit 2 with P=16: edge_count=0 and bit_count=0 next cycle, no sample_done for bit 2, sampled_bit unchanged. Then drop data_sampler_enable only at edge_count=8: no sample_done for that bit.
